// File: rtl/cnn_mul_share_arb_pkg.sv
// Shared widths, requester count and types for the shared-multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_mul_arb_pkg;

    localparam int A_WIDTH  = 7;
    localparam int B_WIDTH  = 9;
    localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = $clog2(NUM_REQ);

    typedef logic [ID_WIDTH-1:0] req_id_t;
    typedef logic [P_WIDTH-1:0]  prod_t;

    // Round-robin successor of a requester index, wrapping at n.
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/cnn_mul_share_arb_if.sv
// Request/response bundle between HLS requesters and the shared multiplier.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests, rsp_ready stalls the response stage.
// Ports: req_valid/req_ready/req_a/req_b (request channel, operands packed per
// requester), rsp_valid (one-hot)/rsp_ready/rsp_p (shared product bus).
interface cnn_mul_share_arb_if
    import cnn_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = cnn_mul_arb_pkg::NUM_REQ,
    parameter int A_WIDTH = cnn_mul_arb_pkg::A_WIDTH,
    parameter int B_WIDTH = cnn_mul_arb_pkg::B_WIDTH
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*A_WIDTH-1:0] req_a;
    logic [NUM_REQ*B_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready;
    logic [P_WIDTH-1:0]         rsp_p;

    // Requester side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p
    );

endinterface

// File: rtl/cnn_mul_share_arb_core.sv
// Unsigned full-precision multiplier placed between the S1 and S2 registers.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the surrounding pipeline decides when the result is used.
// Ports: i_a (A_WIDTH), i_b (B_WIDTH) operands; o_p (A_WIDTH+B_WIDTH) product.
module cnn_mul_u7_u9_core
    import cnn_mul_arb_pkg::*;
#(
    parameter int A_WIDTH = cnn_mul_arb_pkg::A_WIDTH,
    parameter int B_WIDTH = cnn_mul_arb_pkg::B_WIDTH
) (
    input  logic [A_WIDTH-1:0]         i_a,
    input  logic [B_WIDTH-1:0]         i_b,
    output logic [A_WIDTH+B_WIDTH-1:0] o_p
);
    localparam int P_W = A_WIDTH + B_WIDTH;

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_b_ext;

    // Zero-extend both sides first so the product keeps every bit.
    assign w_a_ext = {{(P_W-A_WIDTH){1'b0}}, i_a};
    assign w_b_ext = {{(P_W-B_WIDTH){1'b0}}, i_b};
    assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/cnn_mul_share_arb.sv
// Round-robin scheduler time-sharing one unsigned multiplier among NUM_REQ requesters.
// Latency: 2 cycles from accept to response with no stall; +1 per stalled response cycle.
// Backpressure: a stalled response holds S2; once S1 is also full every req_ready is low.
// Ports: ap_clk, ap_rst (sync, active-high); bus (slave side of the request/response
// bundle); busy = either pipeline stage occupied.
module cnn_mul_share_arb
    import cnn_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = cnn_mul_arb_pkg::NUM_REQ,
    parameter int A_WIDTH = cnn_mul_arb_pkg::A_WIDTH,
    parameter int B_WIDTH = cnn_mul_arb_pkg::B_WIDTH
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    cnn_mul_share_arb_if.slave  bus,
    output logic                busy
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDW-1:0] id_t;

    // Pipeline state
    logic               r_s1_valid;
    id_t                r_s1_id;
    logic [A_WIDTH-1:0] r_s1_a;
    logic [B_WIDTH-1:0] r_s1_b;
    logic               r_s2_valid;
    id_t                r_s2_id;
    logic [P_WIDTH-1:0] r_s2_p;
    id_t                r_rr_ptr;

    // Control
    logic               w_s2_retire;
    logic               w_s2_load;
    logic               w_s1_free;
    logic               w_found;
    id_t                w_grant_id;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic [A_WIDTH-1:0] w_sel_a;
    logic [B_WIDTH-1:0] w_sel_b;
    logic [P_WIDTH-1:0] w_prod;
    logic [NUM_REQ-1:0] w_rsp_valid;

    assign w_s2_retire = r_s2_valid && bus.rsp_ready[r_s2_id];
    assign w_s2_load   = r_s1_valid && (!r_s2_valid || bus.rsp_ready[r_s2_id]);
    assign w_s1_free   = !r_s1_valid || w_s2_load;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(r_rr_ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && bus.req_valid[id_t'(idx)]) begin
                w_found    = 1'b1;
                w_grant_id = id_t'(idx);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found) begin
            w_grant[w_grant_id] = 1'b1;
        end
    end

    // Reset must also suppress the handshake so no requester believes it was accepted.
    assign bus.req_ready = w_grant & {NUM_REQ{w_s1_free && !ap_rst}};
    assign w_accept      = w_found && w_s1_free && !ap_rst;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = bus.req_a[i*A_WIDTH +: A_WIDTH];
                w_sel_b = bus.req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    cnn_mul_u7_u9_core #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH)
    ) u_core (
        .i_a (r_s1_a),
        .i_b (r_s1_b),
        .o_p (w_prod)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_p     <= '0;
            r_rr_ptr   <= '0;
        end else begin
            // S2: a load replaces the retiring result in the same cycle.
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_id    <= r_s1_id;
                r_s2_p     <= w_prod;
            end else if (w_s2_retire) begin
                r_s2_valid <= 1'b0;
            end

            // S1: may reload in the same cycle it hands off to S2.
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_id    <= w_grant_id;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_rr_ptr   <= id_t'(wrap_inc(int'(w_grant_id), NUM_REQ));
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        if (r_s2_valid) begin
            w_rsp_valid[r_s2_id] = 1'b1;
        end
    end

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_p     = r_s2_p;
    assign busy          = r_s1_valid || r_s2_valid;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Directed bench for the shared-multiplier round-robin scheduler.
// Latency: n/a.
// Backpressure: exercised through rsp_ready stalls.
module tb_cnn_mul_share_arb;
    localparam int NR  = 4;
    localparam int A_W = 7;
    localparam int B_W = 9;

    logic ap_clk;
    logic ap_rst;
    logic busy;
    int   total;
    int   bad;

    cnn_mul_share_arb_if #(.NUM_REQ(NR), .A_WIDTH(A_W), .B_WIDTH(B_W)) bus ();

    cnn_mul_share_arb #(.NUM_REQ(NR), .A_WIDTH(A_W), .B_WIDTH(B_W)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus),
        .busy   (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.req_a[i*A_W +: A_W] = a;
        bus.req_b[i*B_W +: B_W] = b;
    endtask

    task automatic do_reset;
        ap_rst        = 1'b1;
        bus.req_valid = '0;
        tick();
        ap_rst        = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_pre: got %b expected 0000", bus.req_ready); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 16'd0) begin bad++; $display("FAIL reset_rsp_p: got %0d expected 0", bus.rsp_p); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready_held: got %b expected 0000", bus.req_ready); end
        ap_rst        = 1'b0;
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_single;
        do_reset();
        bus.rsp_ready = 4'b1111;
        set_ops(0, 7'd127, 9'd511);
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready: got %b expected 0001", bus.req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_s1: got %b expected 1", busy); end
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp_early: got %b expected 0000", bus.rsp_valid); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid: got %b expected 0001", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 16'd64897) begin bad++; $display("FAIL single_rsp_p: got %0d expected 64897", bus.rsp_p); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_s2: got %b expected 1", busy); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL single_rsp_retired: got %b expected 0000", bus.rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_done: got %b expected 0", busy); end
    endtask

    task automatic test_fairness;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_vld;
        logic [15:0] exp_p;
        do_reset();
        bus.rsp_ready = 4'b1111;
        for (int i = 0; i < NR; i++) set_ops(i, 7'(i + 1), 9'd10);
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_rdy = 4'b0001 << (c % 4);
                total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL fair_grant c=%0d: got %b expected %b", c, bus.req_ready, exp_rdy); end
            end
            if (c >= 2) begin
                exp_vld = 4'b0001 << ((c - 2) % 4);
                exp_p   = 16'(10 * (((c - 2) % 4) + 1));
                total++; if (bus.rsp_valid !== exp_vld) begin bad++; $display("FAIL fair_rsp_valid c=%0d: got %b expected %b", c, bus.rsp_valid, exp_vld); end
                total++; if (bus.rsp_p !== exp_p) begin bad++; $display("FAIL fair_rsp_p c=%0d: got %0d expected %0d", c, bus.rsp_p, exp_p); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.rsp_ready = 4'b1101;
        set_ops(1, 7'd5, 9'd7);
        set_ops(2, 7'd6, 9'd9);
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1: got %b expected 0010", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant2: got %b expected 0100", bus.req_ready); end
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.rsp_valid !== 4'b0010) begin bad++; $display("FAIL bp_hold_valid c=%0d: got %b expected 0010", c, bus.rsp_valid); end
            total++; if (bus.rsp_p !== 16'd35) begin bad++; $display("FAIL bp_hold_p c=%0d: got %0d expected 35", c, bus.rsp_p); end
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_low c=%0d: got %b expected 0000", c, bus.req_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy c=%0d: got %b expected 1", c, busy); end
            tick();
        end
        bus.rsp_ready = 4'b1111;
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.rsp_p !== 16'd35) begin bad++; $display("FAIL bp_release_p: got %0d expected 35", bus.rsp_p); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_next_valid: got %b expected 0100", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 16'd54) begin bad++; $display("FAIL bp_next_p: got %0d expected 54", bus.rsp_p); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_drained: got %b expected 0", busy); end
    endtask

    task automatic test_wrap;
        do_reset();
        bus.rsp_ready = 4'b1111;
        set_ops(3, 7'd1, 9'd1);
        set_ops(2, 7'd0, 9'd300);
        bus.req_valid = 4'b1000;
        #1;
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL wrap_grant3: got %b expected 1000", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL wrap_grant2: got %b expected 0100", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.rsp_p !== 16'd1) begin bad++; $display("FAIL wrap_rsp3_p: got %0d expected 1", bus.rsp_p); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0100) begin bad++; $display("FAIL wrap_rsp2_valid: got %b expected 0100", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 16'd0) begin bad++; $display("FAIL wrap_rsp2_p: got %0d expected 0", bus.rsp_p); end
        tick();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        bus.rsp_ready = 4'b0000;
        set_ops(0, 7'd3, 9'd4);
        set_ops(1, 7'd2, 9'd2);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b1111;
        ap_rst        = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_in_reset: got %b expected 0000", bus.req_ready); end
        tick();
        ap_rst        = 1'b0;
        bus.rsp_ready = 4'b1111;
        #1;
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_rsp_valid: got %b expected 0000", bus.rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b expected 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_no_stale_rsp: got %b expected 0000", bus.rsp_valid); end
        tick();
        total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL mid_new_rsp_valid: got %b expected 0001", bus.rsp_valid); end
        total++; if (bus.rsp_p !== 16'd12) begin bad++; $display("FAIL mid_new_rsp_p: got %0d expected 12", bus.rsp_p); end
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        ap_rst        = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_wrap();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
